regfile_mp: RTL

Parametrised multi-port integer register file with a built-in register scoreboard, the successor to the single-write, two-read register file of the sequential core. It serves the pipelined core: `NRD` combinational read ports feed decode, `NWR` synchronous write ports take writeback, and a per-register busy bitmap tracks in-flight destinations so issue logic can stall on RAW hazards. Optional write-to-read bypass removes the one-cycle writeback bubble.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 58 +++++
 rtl/regfile_mp.sv | 113 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: default geometry of the integer register file, plus the register
// index type shared with decode and issue.
//   DEF_XLEN / DEF_NREGS / DEF_NRD / DEF_NWR : default parameter values
//   reg_idx_t                                : architectural register index
package regfile_pkg;
  localparam int DEF_XLEN  = 64;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 2;
  localparam int DEF_NWR   = 1;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bitmap that tracks in-flight producers.
// Priority per register r >= 1: flush clears, then a new issue sets,
// then a writeback clears, otherwise the bit holds. Bit 0 is always 0.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   wr_en, wr_addr    : writeback strobes / destinations (NWR ports)
//   iss_valid, iss_rd : issuing instruction and its destination
//   flush             : clear all busy bits
//   busy_vec          : registered busy bitmap
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int NWR   = DEF_NWR,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
);

  logic [NREGS-1:0] wb_hit;
  logic [NREGS-1:0] busy_nxt;

  // Out-of-range or zero indices never match r in 1..NREGS-1, so they are ignored.
  always_comb begin
    wb_hit = '0;
    for (int r = 1; r < NREGS; r++)
      for (int p = 0; p < NWR; p++)
        if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(r))
          wb_hit[r] = 1'b1;
  end

  always_comb begin
    busy_nxt = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (flush)
        busy_nxt[r] = 1'b0;
      else if (iss_valid && iss_rd == AW'(r))
        busy_nxt[r] = 1'b1;   // new producer beats a same-cycle writeback
      else if (wb_hit[r])
        busy_nxt[r] = 1'b0;
      else
        busy_nxt[r] = busy_vec[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_vec <= '0;
    else     busy_vec <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with RAW scoreboard.
// x0 is hardwired zero; indices >= NREGS read as zero and ignore writes.
// Optional feature macro: REGFILE_BYPASS_EN -- same-cycle write data is
// forwarded to matching read ports and their busy indication is cleared
// (unless the same register is being re-issued this cycle).
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   rd_addr / rd_data / rd_busy : NRD combinational read ports
//   wr_en / wr_addr / wr_data   : NWR synchronous write ports
//   iss_valid, iss_rd           : issue of an instruction with a destination
//   flush                       : clear all busy bits
//   busy_vec                    : registered busy bitmap
//   wr_conflict                 : pulse, two ports wrote the same register last cycle
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = DEF_NRD,
  parameter int NWR   = DEF_NWR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NRD*$clog2(NREGS)-1:0]  rd_addr,
  output logic [NRD*XLEN-1:0]           rd_data,
  output logic [NRD-1:0]                rd_busy,
  input  logic [NWR-1:0]                wr_en,
  input  logic [NWR*$clog2(NREGS)-1:0]  wr_addr,
  input  logic [NWR*XLEN-1:0]           wr_data,
  input  logic                          iss_valid,
  input  logic [$clog2(NREGS)-1:0]      iss_rd,
  input  logic                          flush,
  output logic [NREGS-1:0]              busy_vec,
  output logic                          wr_conflict
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic            conflict_c;

  // Non-zero and inside the implemented register range.
  function automatic logic idx_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < (AW+1)'(NREGS));
  endfunction

  // Storage: ascending port loop makes the highest-index port win.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++)
        for (int p = 0; p < NWR; p++)
          if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(r))
            regs[r] <= wr_data[p*XLEN +: XLEN];
    end
  end

  always_comb begin
    conflict_c = 1'b0;
    for (int p = 0; p < NWR; p++)
      for (int q = p + 1; q < NWR; q++)
        if (wr_en[p] && wr_en[q] && idx_ok(wr_addr[p*AW +: AW]) &&
            wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW])
          conflict_c = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wr_conflict <= 1'b0;
    else     wr_conflict <= conflict_c;
  end

  regfile_scoreboard #(.NREGS(NREGS), .NWR(NWR), .AW(AW)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .busy_vec  (busy_vec)
  );

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] data;
      logic            busy;

      always_comb begin
        ra   = rd_addr[k*AW +: AW];
        data = '0;
        busy = 1'b0;
        if (idx_ok(ra)) begin
          data = regs[ra];
          busy = busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
          for (int p = 0; p < NWR; p++)
            if (wr_en[p] && wr_addr[p*AW +: AW] == ra) begin
              data = wr_data[p*XLEN +: XLEN];
              busy = iss_valid && (iss_rd == ra);
            end
`endif
        end
      end

      assign rd_data[k*XLEN +: XLEN] = data;
      assign rd_busy[k]              = busy;
    end
  endgenerate

endmodule
